pipe_arbiter: RTL and testbench

- Shares one fixed-latency pipelined math unit between `N_REQ` requesters.
- Each cycle it grants at most one requester and drives that requester's operand into the unit.
- A tag pipeline of valid and requester-id bits runs in lockstep with the unit, so each result is routed back to the requester that issued it.
- It owns the unit's `en`: the whole shared pipeline stalls when the result at the head is not accepted.

---
 rtl/pipe_arb_pkg.sv | 34 +++
 rtl/rr_grant.sv | 66 ++++++
 rtl/pipe_arbiter.sv | 101 ++++++++++
 tb/tb_pipe_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_arb_pkg.sv
// pipe_arb_pkg
//   Shared types and helpers for pipe_arbiter.
//   - pipe_arb_tag_t : one stage of the tag pipeline {valid, requester id}.
//   - rr_pick        : index of the first set request bit at or after a
//                      start index, wrapping; -1 when no bit is set.
//   PIPE_ARB_MAX_REQ bounds the number of requesters the tag id field and
//   rr_pick can describe.
package pipe_arb_pkg;

  localparam int PIPE_ARB_MAX_REQ = 64;
  localparam int PIPE_ARB_ID_W    = $clog2(PIPE_ARB_MAX_REQ);

  typedef struct packed {
    logic                     valid;
    logic [PIPE_ARB_ID_W-1:0] id;
  } pipe_arb_tag_t;

  // Walk the candidates from the farthest to the nearest, so the last hit
  // written is the one closest to the start index.
  function automatic int rr_pick(input logic [PIPE_ARB_MAX_REQ-1:0] req,
                                 input int n,
                                 input int start);
    int idx;
    rr_pick = -1;
    for (int i = PIPE_ARB_MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = start + i;
        if (idx >= n) idx = idx - n;
        if (req[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant
//   Picks at most one requester per cycle.
//   Build option PIPE_ARBITER_RR_EN:
//     defined   - round robin; a pointer register remembers where the next
//                 search starts and moves past the winner on each transfer.
//     undefined - fixed priority, lowest valid index wins, no pointer.
//   Ports:
//     clk, rst     clock and asynchronous active-low reset
//     en           high when the granted request is actually transferred
//     req          per-requester request valid
//     grant        one-hot-or-zero winner
//     grant_valid  a winner exists
module rr_grant
  import pipe_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid
);

  int pick;

`ifdef PIPE_ARBITER_RR_EN
  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    pick = rr_pick(PIPE_ARB_MAX_REQ'(req), N_REQ, int'(ptr_q));
  end

  // Pointer moves just past the winner, wrapping from the last index to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (en && grant_valid) begin
      ptr_d = (pick == N_REQ - 1) ? '0 : PW'(pick + 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, en};

  always_comb begin
    pick = rr_pick(PIPE_ARB_MAX_REQ'(req), N_REQ, 0);
  end
`endif

  always_comb begin
    grant_valid = (pick >= 0);
    for (int k = 0; k < N_REQ; k++) begin
      grant[k] = (pick == k);
    end
  end

endmodule

// File: rtl/pipe_arbiter.sv
// pipe_arbiter
//   Shares one fixed-latency pipelined unit between N_REQ requesters. A tag
//   pipeline {valid, id} runs in lockstep with the unit so each result is
//   steered back to the requester that issued it. The arbiter owns the unit
//   enable: everything stalls while the head result is not accepted.
//   Build option PIPE_ARBITER_RR_EN selects round robin (defined) or fixed
//   lowest-index priority (undefined).
//   Ports:
//     clk, rst             clock, asynchronous active-low reset
//     req_valid/req_ready  per-requester request handshake
//     req_data             operands, requester k at [k*WIDTH +: WIDTH]
//     unit_en/unit_in      enable and operand for the shared unit
//     unit_out             result from the shared unit
//     rsp_valid/rsp_ready  per-requester response handshake
//     rsp_data             result, shared by all requesters
module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   unit_en,
  output logic [WIDTH-1:0]       unit_in,
  input  logic [WIDTH-1:0]       unit_out,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_data
);

  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic [IDW-1:0]   grant_id;

  pipe_arb_tag_t tag_q [LATENCY];
  pipe_arb_tag_t tag_d [LATENCY];
  pipe_arb_tag_t head;

  rr_grant #(
    .N_REQ (N_REQ)
  ) u_rr_grant (
    .clk         (clk),
    .rst         (rst),
    .en          (unit_en),
    .req         (req_valid),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Encode the one-hot grant and steer the winner's operand into the unit.
  always_comb begin
    grant_id = '0;
    unit_in  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        grant_id = IDW'(k);
        unit_in  = req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign head = tag_q[LATENCY-1];

  // Decoding the head id per requester keeps rsp_valid one-hot and lets the
  // stall test reuse it instead of indexing rsp_ready by id.
  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rsp_valid[k] = head.valid && (head.id == PIPE_ARB_ID_W'(k));
    end
  end

  assign unit_en   = ~|(rsp_valid & ~rsp_ready);
  assign req_ready = grant & {N_REQ{unit_en & rst}};
  assign rsp_data  = unit_out;

  always_comb begin
    tag_d[0].valid = grant_valid;
    tag_d[0].id    = PIPE_ARB_ID_W'(grant_id);
    for (int s = 1; s < LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // Reset drops every in-flight tag so no stale result is ever presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < LATENCY; s++) tag_q[s] <= '0;
    end else if (unit_en) begin
      tag_q <= tag_d;
    end
  end

endmodule

// File: tb/tb_pipe_arbiter.sv
// tb_pipe_arbiter
//   Drives pipe_arbiter (N_REQ=4, WIDTH=8, LATENCY=3) with a 3-stage
//   enabled delay line standing in for the shared unit. A transaction-level
//   model keeps in-flight requests in a queue with a count of enabled edges
//   still to go, and predicts grants, stalls and responses every cycle.
module tb_pipe_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 3;

  logic              clk;
  logic              rstN;
  logic [NREQ-1:0]   reqValid;
  logic [NREQ*W-1:0] reqData;
  logic [NREQ-1:0]   reqReady;
  logic              unitEn;
  logic [W-1:0]      unitIn;
  logic [W-1:0]      unitOut;
  logic [NREQ-1:0]   rspValid;
  logic [NREQ-1:0]   rspReady;
  logic [W-1:0]      rspData;

  pipe_arbiter #(
    .N_REQ   (NREQ),
    .WIDTH   (W),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rstN),
    .req_valid (reqValid),
    .req_data  (reqData),
    .req_ready (reqReady),
    .unit_en   (unitEn),
    .unit_in   (unitIn),
    .unit_out  (unitOut),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_data  (rspData)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The shared unit: a plain delay line that only moves when enabled.
  logic [W-1:0] unitPipe [LAT];
  always_ff @(posedge clk) begin
    if (unitEn) begin
      unitPipe[0] <= unitIn;
      for (int s = 1; s < LAT; s++) unitPipe[s] <= unitPipe[s-1];
    end
  end
  assign unitOut = unitPipe[LAT-1];

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           remain;
  } flightItem_t;

  flightItem_t inflight[$];
  int          rrPtr;
  int          checkCount;
  int          passCount;
  int          failCount;
  logic        expHead;
  logic        expEn;
  int          expGrant;

  function automatic int modelGrant(input logic [NREQ-1:0] rv, input int ptr);
`ifdef PIPE_ARBITER_RR_EN
    for (int i = 0; i < NREQ; i++) begin
      if (rv[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (rv[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount = checkCount + 1;
    assert (obs === exp) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model for the inputs now applied.
  task automatic checkOutput();
    logic [NREQ-1:0] expRspValid;
    logic [NREQ-1:0] expReqReady;
    logic [W-1:0]    expUnitIn;
    expHead     = rstN && (inflight.size() > 0) && (inflight[0].remain == 0);
    expRspValid = expHead ? (4'b0001 << inflight[0].id) : 4'b0000;
    expEn       = !(expHead && !rspReady[inflight[0].id]);
    expGrant    = modelGrant(reqValid, rrPtr);
    expReqReady = (expGrant >= 0 && expEn && rstN) ? (4'b0001 << expGrant) : 4'b0000;
    expUnitIn   = (expGrant >= 0) ? reqData[expGrant*W +: W] : '0;
    checkVal("rsp_valid", 32'(rspValid), 32'(expRspValid));
    checkVal("unit_en",   32'(unitEn),   32'(expEn));
    checkVal("req_ready", 32'(reqReady), 32'(expReqReady));
    checkVal("unit_in",   32'(unitIn),   32'(expUnitIn));
    if (expHead) checkVal("rsp_data", 32'(rspData), 32'(inflight[0].data));
  endtask

  // Advance the model across one rising edge.
  task automatic updateModel();
    if (!rstN) begin
      inflight.delete();
      rrPtr = 0;
    end else if (expEn) begin
      if (expHead) void'(inflight.pop_front());
      foreach (inflight[i]) if (inflight[i].remain > 0) inflight[i].remain--;
      if (expGrant >= 0) begin
        inflight.push_back('{id: expGrant, data: reqData[expGrant*W +: W], remain: LAT - 1});
        rrPtr = (expGrant + 1) % NREQ;
      end
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] rv, input logic [NREQ*W-1:0] rd,
                               input logic [NREQ-1:0] rr, input logic r);
    reqValid = rv;
    reqData  = rd;
    rspReady = rr;
    rstN     = r;
    if (!r) begin
      inflight.delete();
      rrPtr = 0;
    end
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] rndReady;
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    rrPtr      = 0;
    reqValid   = '0;
    reqData    = '0;
    rspReady   = '0;
    rstN       = 1'b0;
    @(posedge clk);
    #1;

    // Reset state: no grants, no responses, unit enabled.
    applyStimulus(4'b1111, 32'h44332211, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b0);

    // Single requester streaming three operands.
    applyStimulus(4'b0001, 32'h00000011, 4'b1111, 1'b1);
    applyStimulus(4'b0001, 32'h00000022, 4'b1111, 1'b1);
    applyStimulus(4'b0001, 32'h00000033, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b1);

    // All requesters busy: arbitration order and per-index routing.
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, $urandom, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b1);

    // Requesters 1 and 3 only: priority or alternation depending on build.
    for (int i = 0; i < 6; i++) applyStimulus(4'b1010, $urandom, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b1);

    // Backpressure on requester 2, then release.
    for (int i = 0; i < 3; i++) applyStimulus(4'b0100, $urandom, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0100, $urandom, 4'b1011, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b1);

    // Sparse requests with nobody accepting responses.
    for (int i = 0; i < 10; i++)
      applyStimulus((i == 0 || i == 5) ? 4'b0001 : 4'b0000, $urandom, 4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b1);

    // Reset with requests in flight, then a fresh start.
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, $urandom, 4'b1111, 1'b1);
    applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b1);
    applyStimulus(4'b1111, $urandom, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b1);

    // Random traffic with mostly-ready responders.
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b < NREQ; b++) rndReady[b] = ($urandom_range(3) != 0);
      applyStimulus(4'($urandom), $urandom, rndReady, 1'b1);
    end
    for (int i = 0; i < 6; i++) applyStimulus(4'b0000, 32'h0, 4'b1111, 1'b1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
